// File: rtl/ber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ber_pkg
// Description : Shared types and constants for the BER test-pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package ber_pkg;

    localparam int BER_WORD_W    = 10;
    localparam int BER_SEG_W     = 12;
    localparam int BER_WORD_SEGS = 4;
    localparam int BER_ERR_SEGS  = 3;

    localparam logic [BER_WORD_W-1:0] BER_MASK_RST = {{(BER_WORD_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ber_state_e;

    function automatic logic [BER_WORD_W-1:0] ber_rotl1(input logic [BER_WORD_W-1:0] v);
        return {v[BER_WORD_W-2:0], v[BER_WORD_W-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_counter.sv
`default_nettype none
// ============================================================================
// Module      : seg_counter
// Description : Wrapping counter built from cascaded SEG_W-bit segments.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_counter
    import ber_pkg::*;
#(
    parameter int SEG_W = BER_SEG_W,
    parameter int SEGS  = BER_WORD_SEGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  clear,
    output logic [SEG_W*SEGS-1:0] count
);

    logic [SEG_W*SEGS-1:0] cnt_q;
    logic [SEG_W*SEGS-1:0] cnt_d;
    logic [SEGS-1:0]       w_carry;

    genvar gi;
    generate
        for (gi = 0; gi < SEGS; gi++) begin : g_seg
            // Carry looks straight at the lower segments so there is no ripple chain through w_carry.
            if (gi == 0) begin : g_lsb
                assign w_carry[gi] = inc;
            end else begin : g_upper
                assign w_carry[gi] = inc & (&cnt_q[gi*SEG_W-1:0]);
            end
            assign cnt_d[gi*SEG_W +: SEG_W] = clear ? '0
                : cnt_q[gi*SEG_W +: SEG_W] + {{(SEG_W-1){1'b0}}, w_carry[gi]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ber_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : ber_pattern_gen
// Description : Fixed-word BER test pattern generator with optional single-bit
//               error injection (enabled by defining BER_ERR_INJECT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module ber_pattern_gen
    import ber_pkg::*;
#(
    parameter int INJ_W = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                start,
    input  logic                                stop,
    input  logic [BER_WORD_W-1:0]               pattern,
    input  logic [3:0]                          word_interval,
    input  logic [INJ_W-1:0]                    inject_period,
    input  logic                                inject_once,
    output logic [BER_WORD_W-1:0]               data_10b,
    output logic                                data_ready,
    output logic                                busy,
    output logic [BER_SEG_W*BER_WORD_SEGS-1:0]  word_count,
    output logic [BER_SEG_W*BER_ERR_SEGS-1:0]   injected_count
);

    ber_state_e            state_q, state_d;
    logic [3:0]            gap_q, gap_d;
    logic                  rdy_q;
    logic [BER_WORD_W-1:0] data_q;
    logic                  w_emit;
    logic                  w_start;
    logic                  w_corrupt;
    logic [BER_WORD_W-1:0] w_word;

    // Everything is gated by enable here, so a low enable holds state and drops pulses.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        w_emit  = 1'b0;
        w_start = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d = RUN;
                        gap_d   = '0;
                        w_start = 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (gap_q == '0) begin
                        w_emit = 1'b1;
                        gap_d  = word_interval;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q  <= 1'b0;
            data_q <= '0;
        end else begin
            rdy_q <= w_emit;
            if (w_emit) begin
                data_q <= w_word;
            end
        end
    end

`ifdef BER_ERR_INJECT_EN
    localparam logic [INJ_W-1:0] c_inj_one = {{(INJ_W-1){1'b0}}, 1'b1};

    logic [INJ_W-1:0]      per_q, per_d;
    logic                  pend_q, pend_d;
    logic [BER_WORD_W-1:0] mask_q, mask_d;
    logic                  w_per_hit;

    // A one-shot pulse coinciding with an emission is consumed by that same word.
    always_comb begin
        w_per_hit = (inject_period != '0) && (per_q == inject_period - c_inj_one);
        w_corrupt = w_emit && (w_per_hit || pend_q || inject_once);
        per_d     = per_q;
        pend_d    = pend_q;
        mask_d    = mask_q;
        if (w_start) begin
            per_d = '0;
        end else if (w_emit) begin
            per_d = w_per_hit ? '0 : per_q + c_inj_one;
        end
        if (w_emit) begin
            pend_d = 1'b0;
        end else if (enable && inject_once) begin
            pend_d = 1'b1;
        end
        if (w_corrupt) begin
            mask_d = ber_rotl1(mask_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q  <= '0;
            pend_q <= 1'b0;
            mask_q <= BER_MASK_RST;
        end else begin
            per_q  <= per_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

    assign w_word = pattern ^ (w_corrupt ? mask_q : '0);

    seg_counter #(
        .SEG_W (BER_SEG_W),
        .SEGS  (BER_ERR_SEGS)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_corrupt),
        .clear (1'b0),
        .count (injected_count)
    );
`else
    logic unused_inj;

    assign w_corrupt      = 1'b0;
    assign w_word         = pattern;
    assign injected_count = '0;
    assign unused_inj     = ^{inject_period, inject_once, w_start, w_corrupt};
`endif

    seg_counter #(
        .SEG_W (BER_SEG_W),
        .SEGS  (BER_WORD_SEGS)
    ) u_word_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_emit),
        .clear (1'b0),
        .count (word_count)
    );

    assign data_10b   = data_q;
    assign data_ready = rdy_q;
    assign busy       = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_ber_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ber_pattern_gen
// Description : Self-checking bench for ber_pattern_gen against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ber_pattern_gen;

`ifdef BER_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, enable, start, stop, inject_once;
    logic [9:0]  pattern;
    logic [3:0]  word_interval;
    logic [15:0] inject_period;
    logic [9:0]  data_10b;
    logic        data_ready, busy;
    logic [47:0] word_count;
    logic [35:0] injected_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_run, m_pend;
    int          m_cyc, m_next, m_bit;
    logic [15:0] m_since;
    logic        m_ready;
    logic [9:0]  m_data;
    logic [47:0] m_words;
    logic [35:0] m_inj;

    ber_pattern_gen #(.INJ_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .start          (start),
        .stop           (stop),
        .pattern        (pattern),
        .word_interval  (word_interval),
        .inject_period  (inject_period),
        .inject_once    (inject_once),
        .data_10b       (data_10b),
        .data_ready     (data_ready),
        .busy           (busy),
        .word_count     (word_count),
        .injected_count (injected_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_cyc = 0; m_next = 0; m_bit = 0; m_since = '0;
        m_ready = 0; m_data = '0; m_words = '0; m_inj = '0;
    endtask

    // Word-level view: words fall every word_interval+1 enabled cycles after start.
    task automatic model_edge();
        bit emit, hit, once, corrupt;
        if (!enable) begin
            m_ready = 0;
            return;
        end
        m_cyc++;
        m_ready = 0;
        emit = 0;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_next = m_cyc + 1; m_since = '0;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (m_cyc == m_next) begin
            emit = 1;
            m_next = m_cyc + int'(word_interval) + 1;
        end
        if (emit) begin
            hit     = INJ && (inject_period != 0) && (m_since == inject_period - 16'd1);
            once    = INJ && (m_pend || inject_once);
            corrupt = hit || once;
            if (INJ) m_since = hit ? 16'd0 : m_since + 16'd1;
            m_pend  = 0;
            m_data  = pattern ^ (corrupt ? 10'(1 << m_bit) : 10'd0);
            if (corrupt) begin
                m_bit = (m_bit + 1) % 10;
                m_inj++;
            end
            m_words++;
            m_ready = 1;
        end else if (INJ && inject_once) begin
            m_pend = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; enable = 0; start = 0; stop = 0; inject_once = 0;
        pattern = '0; word_interval = '0; inject_period = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({busy, data_ready, data_10b, word_count, injected_count} !== '0) begin
            errors++;
            $display("FAIL reset: got b=%0b r=%0b d=%h wc=%h ic=%h exp all zero",
                     busy, data_ready, data_10b, word_count, injected_count);
        end
        rst = 0; enable = 1;
    endtask

    task automatic test_basic();
        logic [47:0] wc0;
        pattern = 10'h17C; word_interval = 0; inject_period = 0;
        start = 1; step(); start = 0;
        wc0 = m_words;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({busy, data_ready, data_10b, word_count, injected_count} !== {m_run, m_ready, m_data, m_words, m_inj}) begin
                errors++;
                $display("FAIL basic: got b=%0b r=%0b d=%h wc=%h ic=%h exp b=%0b r=%0b d=%h wc=%h ic=%h",
                         busy, data_ready, data_10b, word_count, injected_count, m_run, m_ready, m_data, m_words, m_inj);
            end
            if (i < 8) step();
        end
        checks++;
        if (word_count !== wc0 + 48'd8 || data_10b !== 10'h17C) begin
            errors++;
            $display("FAIL basic_count: got wc=%h d=%h exp wc=%h d=17c", word_count, data_10b, wc0 + 48'd8);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_interval();
        logic [47:0] wc0;
        int strobes, last;
        word_interval = 3; pattern = 10'h2B1;
        start = 1; step(); start = 0;
        wc0 = m_words; strobes = 0; last = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if ({busy, data_ready, data_10b, word_count, injected_count} !== {m_run, m_ready, m_data, m_words, m_inj}) begin
                errors++;
                $display("FAIL interval: got b=%0b r=%0b d=%h wc=%h exp b=%0b r=%0b d=%h wc=%h",
                         busy, data_ready, data_10b, word_count, m_run, m_ready, m_data, m_words);
            end
            if (data_ready) begin
                checks++;
                if (last >= 0 && i - last != 4) begin
                    errors++;
                    $display("FAIL interval_spacing: got %0d exp 4", i - last);
                end
                last = i; strobes++;
            end
        end
        checks++;
        if (strobes != 5 || word_count !== wc0 + 48'd5) begin
            errors++;
            $display("FAIL interval_count: got strobes=%0d wc=%h exp 5 wc=%h", strobes, word_count, wc0 + 48'd5);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_start_stop_enable();
        logic [47:0] snap;
        word_interval = 0;
        start = 1; stop = 1; step(); start = 0; stop = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || data_ready !== 1'b0) begin
                errors++;
                $display("FAIL start_stop_idle: got b=%0b r=%0b exp 0 0", busy, data_ready);
            end
            step();
        end
        start = 1; step(); start = 0;
        repeat (3) step();
        stop = 1; step(); stop = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || data_ready !== 1'b0 || word_count !== m_words) begin
                errors++;
                $display("FAIL stop_mid_run: got b=%0b r=%0b wc=%h exp 0 0 wc=%h", busy, data_ready, word_count, m_words);
            end
            step();
        end
        start = 1; step(); start = 0;
        repeat (3) step();
        snap = m_words;
        enable = 0; stop = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            stop = 0;
            checks++;
            if (data_ready !== 1'b0 || word_count !== snap || busy !== 1'b1) begin
                errors++;
                $display("FAIL enable_freeze: got r=%0b wc=%h b=%0b exp 0 wc=%h b=1", data_ready, word_count, busy, snap);
            end
        end
        enable = 1; step();
        checks++;
        if ({busy, data_ready, data_10b, word_count, injected_count} !== {m_run, m_ready, m_data, m_words, m_inj}) begin
            errors++;
            $display("FAIL enable_resume: got b=%0b r=%0b wc=%h exp b=%0b r=%0b wc=%h",
                     busy, data_ready, word_count, m_run, m_ready, m_words);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_inject();
        int k, n;
        logic [35:0] ic0;
        rst = 1; @(posedge clk); #1; model_reset(); rst = 0;
        pattern = 10'h2A5; word_interval = 0; inject_period = 4;
        start = 1; step(); start = 0;
        k = 0; n = 0;
        while (k < 40 && n < 60) begin
            step(); n++;
            checks++;
            if ({busy, data_ready, data_10b, word_count, injected_count} !== {m_run, m_ready, m_data, m_words, m_inj}) begin
                errors++;
                $display("FAIL inject_model: got r=%0b d=%h ic=%h exp r=%0b d=%h ic=%h",
                         data_ready, data_10b, injected_count, m_ready, m_data, m_inj);
            end
            if (data_ready) begin
                k++;
                checks++;
                if ((data_10b ^ 10'h2A5) !== ((INJ && k % 4 == 0) ? 10'(1 << ((k / 4 - 1) % 10)) : 10'd0)) begin
                    errors++;
                    $display("FAIL inject_bit: word %0d got flip=%h", k, data_10b ^ 10'h2A5);
                end
            end
        end
        checks++;
        if (k != 40 || injected_count !== (INJ ? 36'd10 : 36'd0)) begin
            errors++;
            $display("FAIL inject_total: got words=%0d ic=%h exp 40 ic=%0d", k, injected_count, INJ ? 10 : 0);
        end
        word_interval = 2;
        n = 0;
        while (k < 43 && n < 20) begin
            step(); n++;
            if (data_ready) k++;
        end
        ic0 = m_inj;
        inject_once = 1; step(); inject_once = 0;
        n = 0;
        while (!data_ready && n < 10) begin
            step(); n++;
        end
        checks++;
        if (!data_ready || (data_10b ^ 10'h2A5) !== (INJ ? 10'h001 : 10'h000)
            || injected_count !== ic0 + (INJ ? 36'd1 : 36'd0)
            || {data_10b, injected_count} !== {m_data, m_inj}) begin
            errors++;
            $display("FAIL inject_combined: got r=%0b flip=%h ic=%h exp flip=%h ic=%h",
                     data_ready, data_10b ^ 10'h2A5, injected_count, INJ ? 10'h001 : 10'h000, m_inj);
        end
        stop = 1; step(); stop = 0; inject_period = 0;
    endtask

    task automatic test_rollover();
        force dut.u_word_cnt.cnt_q = 48'h000_000_FFF_FFF;
        #1;
        release dut.u_word_cnt.cnt_q;
        m_words = 48'h000_000_FFF_FFF;
        word_interval = 15;
        start = 1; step(); start = 0;
        step();
        checks++;
        if (data_ready !== 1'b1 || word_count !== 48'h000_001_000_000) begin
            errors++;
            $display("FAIL rollover: got r=%0b wc=%h exp 1 wc=000001000000", data_ready, word_count);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enable      = ($urandom % 8) != 0;
            start       = ($urandom % 12) == 0;
            stop        = ($urandom % 40) == 0;
            inject_once = ($urandom % 16) == 0;
            pattern     = 10'($urandom);
            if ($urandom % 20 == 0) word_interval = 4'($urandom_range(0, 3));
            if ($urandom % 50 == 0) inject_period = 16'($urandom_range(0, 5));
            step();
            checks++;
            if ({busy, data_ready, data_10b, word_count, injected_count} !== {m_run, m_ready, m_data, m_words, m_inj}) begin
                errors++;
                $display("FAIL random cyc %0d: got b=%0b r=%0b d=%h wc=%h ic=%h exp b=%0b r=%0b d=%h wc=%h ic=%h",
                         i, busy, data_ready, data_10b, word_count, injected_count, m_run, m_ready, m_data, m_words, m_inj);
            end
        end
        enable = 1; start = 0; stop = 1; inject_once = 0;
        step(); stop = 0;
    endtask

    task automatic test_async_reset();
        word_interval = 0;
        start = 1; step(); start = 0;
        step(); step();
        #2 rst = 1;
        #1;
        checks++;
        if (data_ready !== 1'b0 || busy !== 1'b0 || word_count !== 48'd0 || injected_count !== 36'd0) begin
            errors++;
            $display("FAIL async_reset: got r=%0b b=%0b wc=%h ic=%h exp all zero", data_ready, busy, word_count, injected_count);
        end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interval();
        test_start_stop_enable();
        test_inject();
        test_rollover();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
